// File: rtl/div_arbiter.sv
// rtl/div_arbiter.sv - round-robin sharing of one iterative divider between NUM_REQ requesters
// Optional DIV_ARB_ZERO_BYPASS_EN: divide-by-zero is answered locally, the divider is never kicked.
module div_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ-1:0]       req_unsigned,
   input  logic [NUM_REQ-1:0]       req_rem,
   input  logic [NUM_REQ*WIDTH-1:0] req_a,
   input  logic [NUM_REQ*WIDTH-1:0] req_b,
   output logic [NUM_REQ-1:0]       rsp_valid,
   output logic [WIDTH-1:0]         rsp_data,
   output logic                     busy,
   output logic                     div_kick,
   output logic                     div_unsigned_flag,
   output logic [WIDTH-1:0]         div_dividend,
   output logic [WIDTH-1:0]         div_divider,
   input  logic                     div_ready,
   input  logic [WIDTH-1:0]         div_quotient,
   input  logic [WIDTH-1:0]         div_remainder
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {IDLE, KICK, WAIT, RESP} state_t;

   state_t          state;
   logic [PW-1:0]   rr_ptr;
   logic [PW-1:0]   grant;
   logic [PW-1:0]   winner;
   logic [PW-1:0]   cand;
   logic [PW-1:0]   next_ptr;
   logic            found;
   logic            guard;
   logic            rem_sel;
   logic [WIDTH-1:0] sel_a;
   logic [WIDTH-1:0] sel_b;
   logic            sel_u;
   logic            sel_rem;

   // Search upward from rr_ptr, wrapping at NUM_REQ, for the first pending request.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      cand   = rr_ptr;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && req_valid[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
         cand = (cand == PW'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
      end
   end

   assign next_ptr = (winner == PW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

   always_comb begin
      sel_a   = '0;
      sel_b   = '0;
      sel_u   = 1'b0;
      sel_rem = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (PW'(i) == winner) begin
            sel_a   = req_a[i*WIDTH +: WIDTH];
            sel_b   = req_b[i*WIDTH +: WIDTH];
            sel_u   = req_unsigned[i];
            sel_rem = req_rem[i];
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (state == IDLE && found && !reset)
         req_ready[winner] = 1'b1;
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state             <= IDLE;
         rr_ptr            <= '0;
         grant             <= '0;
         guard             <= 1'b0;
         rem_sel           <= 1'b0;
         rsp_valid         <= '0;
         rsp_data          <= '0;
         div_kick          <= 1'b0;
         div_unsigned_flag <= 1'b0;
         div_dividend      <= '0;
         div_divider       <= '0;
      end else begin
         rsp_valid <= '0;
         div_kick  <= 1'b0;
         case (state)
            IDLE: begin
               if (found) begin
                  grant             <= winner;
                  rem_sel           <= sel_rem;
                  div_unsigned_flag <= sel_u;
                  div_dividend      <= sel_a;
                  div_divider       <= sel_b;
                  rr_ptr            <= next_ptr;
`ifdef DIV_ARB_ZERO_BYPASS_EN
                  if (sel_b == '0) begin
                     state             <= RESP;
                     rsp_valid[winner] <= 1'b1;
                     rsp_data          <= sel_rem ? sel_a : '1;
                  end else begin
                     state    <= KICK;
                     div_kick <= 1'b1;
                  end
`else
                  state    <= KICK;
                  div_kick <= 1'b1;
`endif
               end
            end
            KICK: begin
               state <= WAIT;
               guard <= 1'b1;
            end
            WAIT: begin
               // Divider ready may still be high from its idle period on the first cycle.
               if (guard) begin
                  guard <= 1'b0;
               end else if (div_ready) begin
                  rsp_data         <= rem_sel ? div_remainder : div_quotient;
                  rsp_valid[grant] <= 1'b1;
                  state            <= RESP;
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_arbiter.sv
// tb/tb_div_arbiter.sv - randomized self-checking bench for div_arbiter with a behavioural divider
module tb_div_arbiter;

   localparam int N = 4;
   localparam int W = 32;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_ready;
   logic [N-1:0]   req_unsigned;
   logic [N-1:0]   req_rem;
   logic [N*W-1:0] req_a;
   logic [N*W-1:0] req_b;
   logic [N-1:0]   rsp_valid;
   logic [W-1:0]   rsp_data;
   logic           busy;
   logic           div_kick;
   logic           div_unsigned_flag;
   logic [W-1:0]   div_dividend;
   logic [W-1:0]   div_divider;
   logic           div_ready;
   logic [W-1:0]   div_quotient;
   logic [W-1:0]   div_remainder;

   int tests_run = 0;
   int tests_failed = 0;

   logic [N-1:0] pend;
   logic [N-1:0] acc_last;
   bit           hold_all;
   logic [W-1:0] op_a [N];
   logic [W-1:0] op_b [N];
   logic [N-1:0] op_u;
   logic [N-1:0] op_r;

   int           grant_q[$];
   logic [W-1:0] exp_q[$];
   logic [N-1:0] mask_q[$];
   int           rsp_idx_q[$];
   logic [W-1:0] rsp_data_q[$];
   int cyc, kick_cnt, onehot_err, acc_cyc, rsp_cyc;

   div_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_unsigned(req_unsigned), .req_rem(req_rem),
      .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
      .div_kick(div_kick), .div_unsigned_flag(div_unsigned_flag),
      .div_dividend(div_dividend), .div_divider(div_divider),
      .div_ready(div_ready), .div_quotient(div_quotient), .div_remainder(div_remainder)
   );

   always #5 clk = ~clk;

   // RISC-V division semantics, including divide-by-zero and signed overflow.
   function automatic logic [W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic u, input logic r);
      logic signed [W-1:0] sa;
      logic signed [W-1:0] sb;
      sa = a;
      sb = b;
      if (b == '0) return r ? a : '1;
      if (u) return r ? a % b : a / b;
      if (a == {1'b1, {(W-1){1'b0}}} && b == '1) return r ? '0 : a;
      return r ? sa % sb : sa / sb;
   endfunction

   // Divider model: ready drops one cycle after the kick and stale junk sits on the result lines meanwhile.
   logic         div_started;
   int           div_cnt;
   logic [W-1:0] pend_q, pend_r;
   always @(posedge clk) begin
      if (reset) begin
         div_ready     <= 1'b1;
         div_started   <= 1'b0;
         div_cnt       <= 0;
         div_quotient  <= '0;
         div_remainder <= '0;
      end else if (div_kick) begin
         div_started   <= 1'b1;
         div_quotient  <= 32'hDEAD_0BAD;
         div_remainder <= 32'h0BAD_F00D;
         pend_q        <= ref_div(div_dividend, div_divider, div_unsigned_flag, 1'b0);
         pend_r        <= ref_div(div_dividend, div_divider, div_unsigned_flag, 1'b1);
         div_cnt       <= $urandom_range(1, 4);
      end else if (div_started) begin
         div_started <= 1'b0;
         div_ready   <= 1'b0;
      end else if (!div_ready) begin
         if (div_cnt <= 1) begin
            div_ready     <= 1'b1;
            div_quotient  <= pend_q;
            div_remainder <= pend_r;
         end
         div_cnt <= div_cnt - 1;
      end
   end

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         req_valid[i]      = pend[i] | hold_all;
         req_unsigned[i]   = op_u[i];
         req_rem[i]        = op_r[i];
         req_a[i*W +: W]   = op_a[i];
         req_b[i*W +: W]   = op_b[i];
      end
   endtask

   task automatic clear_obs();
      grant_q.delete(); exp_q.delete(); mask_q.delete();
      rsp_idx_q.delete(); rsp_data_q.delete();
      cyc = 0; kick_cnt = 0; onehot_err = 0; acc_cyc = 0; rsp_cyc = 0;
   endtask

   // One clock: record registered outputs, update requester inputs, then record this cycle's grant.
   task automatic cycle();
      @(posedge clk);
      #1;
      cyc++;
      if (div_kick) kick_cnt++;
      if (rsp_valid != '0) begin
         if ($countones(rsp_valid) != 1) onehot_err++;
         for (int i = 0; i < N; i++) if (rsp_valid[i]) rsp_idx_q.push_back(i);
         rsp_data_q.push_back(rsp_data);
         rsp_cyc = cyc;
      end
      for (int i = 0; i < N; i++) if (acc_last[i] && !hold_all) pend[i] = 1'b0;
      drive();
      #1;
      if ($countones(req_ready) > 1) onehot_err++;
      acc_last = req_ready;
      for (int i = 0; i < N; i++) begin
         if (req_ready[i]) begin
            grant_q.push_back(i);
            exp_q.push_back(ref_div(op_a[i], op_b[i], op_u[i], op_r[i]));
            mask_q.push_back(req_valid);
            acc_cyc = cyc;
         end
      end
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      pend = '0;
      hold_all = 1'b0;
      acc_last = '0;
      for (int i = 0; i < N; i++) begin
         op_a[i] = '0; op_b[i] = '0; op_u[i] = 1'b0; op_r[i] = 1'b0;
      end
      drive();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      clear_obs();
   endtask

   task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic u, input logic r);
      op_a[i] = a; op_b[i] = b; op_u[i] = u; op_r[i] = r;
      pend[i] = 1'b1;
   endtask

   task automatic drain(input int budget, output bit timed_out);
      int k;
      k = 0;
      timed_out = 1'b1;
      while (k <= budget) begin
         if (pend == '0 && !hold_all && grant_q.size() == rsp_idx_q.size() && !busy) begin
            timed_out = 1'b0;
            break;
         end
         cycle();
         k++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      pend = '0;
      drive();
      repeat (2) @(posedge clk);
      #1;
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %0b want 0", busy); end
      tests_run++; if (rsp_valid !== '0) begin tests_failed++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
      tests_run++; if (rsp_data !== '0) begin tests_failed++; $display("FAIL reset_rsp_data got %h want 0", rsp_data); end
      tests_run++; if (div_kick !== 1'b0) begin tests_failed++; $display("FAIL reset_div_kick got %0b want 0", div_kick); end
      tests_run++; if (req_ready !== '0) begin tests_failed++; $display("FAIL reset_req_ready got %b want 0", req_ready); end
      tests_run++; if (div_dividend !== '0 || div_divider !== '0 || div_unsigned_flag !== 1'b0) begin
         tests_failed++; $display("FAIL reset_div_operands got %h/%h/%0b want 0/0/0", div_dividend, div_divider, div_unsigned_flag);
      end
      reset = 1'b0;
   endtask

   task automatic test_basic();
      bit to;
      apply_reset();
      set_op(1, 100, 7, 1'b1, 1'b0);
      drain(100, to);
      tests_run++; if (to) begin tests_failed++; $display("FAIL basic_timeout got timeout want response"); end
      tests_run++; if (grant_q.size() != 1 || grant_q[0] != 1) begin
         tests_failed++; $display("FAIL basic_grant got %0d grants (first %0d) want one grant to 1", grant_q.size(), (grant_q.size() > 0) ? grant_q[0] : -1);
      end
      tests_run++; if (kick_cnt != 1) begin tests_failed++; $display("FAIL basic_kicks got %0d want 1", kick_cnt); end
      tests_run++; if (rsp_idx_q.size() != 1 || rsp_idx_q[0] != 1 || rsp_data_q[0] !== 32'd14) begin
         tests_failed++; $display("FAIL basic_quot got %0d rsps (data %0d) want one rsp on 1 with 14", rsp_idx_q.size(), (rsp_data_q.size() > 0) ? rsp_data_q[0] : 0);
      end
      clear_obs();
      set_op(1, 100, 7, 1'b1, 1'b1);
      drain(100, to);
      tests_run++; if (to || rsp_idx_q.size() != 1 || rsp_idx_q[0] != 1 || rsp_data_q[0] !== 32'd2) begin
         tests_failed++; $display("FAIL basic_rem got %0d rsps (data %0d) want one rsp on 1 with 2", rsp_idx_q.size(), (rsp_data_q.size() > 0) ? rsp_data_q[0] : 0);
      end
   endtask

   task automatic test_signed();
      bit to;
      apply_reset();
      set_op(0, 32'hFFFF_FFF9, 2, 1'b0, 1'b0);
      drain(100, to);
      tests_run++; if (to || rsp_idx_q.size() != 1 || rsp_idx_q[0] != 0 || rsp_data_q[0] !== 32'hFFFF_FFFD) begin
         tests_failed++; $display("FAIL signed_quot got %0d rsps (data %h) want one rsp on 0 with fffffffd", rsp_idx_q.size(), (rsp_data_q.size() > 0) ? rsp_data_q[0] : 0);
      end
      clear_obs();
      set_op(0, 32'hFFFF_FFF9, 2, 1'b0, 1'b1);
      drain(100, to);
      tests_run++; if (to || rsp_idx_q.size() != 1 || rsp_data_q[0] !== 32'hFFFF_FFFF) begin
         tests_failed++; $display("FAIL signed_rem got %0d rsps (data %h) want ffffffff", rsp_idx_q.size(), (rsp_data_q.size() > 0) ? rsp_data_q[0] : 0);
      end
   endtask

   task automatic test_two_same_cycle();
      bit to;
      apply_reset();
      set_op(0, 50, 5, 1'b1, 1'b0);
      set_op(2, 83, 9, 1'b1, 1'b1);
      drain(200, to);
      tests_run++; if (to || grant_q.size() != 2 || grant_q[0] != 0 || grant_q[1] != 2) begin
         tests_failed++; $display("FAIL pair_grant_order got %0d grants want 0 then 2", grant_q.size());
      end
      tests_run++; if (rsp_idx_q.size() != 2 || rsp_idx_q[0] != 0 || rsp_idx_q[1] != 2 || rsp_data_q[0] !== 32'd10 || rsp_data_q[1] !== 32'd2) begin
         tests_failed++; $display("FAIL pair_responses got %0d rsps want 0:10 then 2:2", rsp_idx_q.size());
      end
      tests_run++; if (onehot_err != 0) begin tests_failed++; $display("FAIL pair_onehot got %0d multi-bit cycles want 0", onehot_err); end
   endtask

   task automatic test_round_robin_all();
      bit to;
      int k;
      int exp_g[6] = '{0, 1, 2, 3, 0, 1};
      apply_reset();
      for (int i = 0; i < N; i++) set_op(i, 1000 + i * 37, i + 3, 1'b1, i[0]);
      hold_all = 1'b1;
      k = 0;
      while (grant_q.size() < 6 && k < 400) begin
         cycle();
         k++;
      end
      hold_all = 1'b0;
      pend = '0;
      drain(200, to);
      tests_run++; if (to || grant_q.size() != 6) begin tests_failed++; $display("FAIL rr_grant_count got %0d want 6", grant_q.size()); end
      for (int g = 0; g < 6 && g < grant_q.size(); g++) begin
         tests_run++; if (grant_q[g] != exp_g[g]) begin tests_failed++; $display("FAIL rr_grant_%0d got %0d want %0d", g, grant_q[g], exp_g[g]); end
      end
      tests_run++; if (kick_cnt != grant_q.size()) begin tests_failed++; $display("FAIL rr_kicks got %0d want %0d", kick_cnt, grant_q.size()); end
      tests_run++; if (rsp_idx_q.size() != grant_q.size()) begin tests_failed++; $display("FAIL rr_rsp_count got %0d want %0d", rsp_idx_q.size(), grant_q.size()); end
      for (int g = 0; g < rsp_idx_q.size() && g < grant_q.size(); g++) begin
         tests_run++; if (rsp_idx_q[g] != grant_q[g] || rsp_data_q[g] !== exp_q[g]) begin
            tests_failed++; $display("FAIL rr_rsp_%0d got %0d:%h want %0d:%h", g, rsp_idx_q[g], rsp_data_q[g], grant_q[g], exp_q[g]);
         end
      end
      tests_run++; if (onehot_err != 0) begin tests_failed++; $display("FAIL rr_onehot got %0d want 0", onehot_err); end
   endtask

   task automatic test_reset_in_wait();
      bit to;
      int k;
      apply_reset();
      set_op(3, 9999, 7, 1'b1, 1'b0);
      k = 0;
      while (grant_q.size() == 0 && k < 20) begin
         cycle();
         k++;
      end
      tests_run++; if (grant_q.size() != 1) begin tests_failed++; $display("FAIL rstwait_grant got %0d want 1", grant_q.size()); end
      cycle();
      cycle();
      reset = 1'b1;
      @(posedge clk);
      #1;
      tests_run++; if (busy !== 1'b0 || div_kick !== 1'b0 || rsp_valid !== '0) begin
         tests_failed++; $display("FAIL rstwait_outputs got busy=%0b kick=%0b rsp=%b want 0/0/0", busy, div_kick, rsp_valid);
      end
      reset = 1'b0;
      acc_last = '0;
      repeat (20) cycle();
      tests_run++; if (rsp_idx_q.size() != 0) begin tests_failed++; $display("FAIL rstwait_dropped got %0d rsps want 0", rsp_idx_q.size()); end
      clear_obs();
      set_op(2, 9, 3, 1'b1, 1'b0);
      drain(100, to);
      tests_run++; if (to || rsp_idx_q.size() != 1 || rsp_idx_q[0] != 2 || rsp_data_q[0] !== 32'd3) begin
         tests_failed++; $display("FAIL rstwait_fresh got %0d rsps (data %0d) want one rsp on 2 with 3", rsp_idx_q.size(), (rsp_data_q.size() > 0) ? rsp_data_q[0] : 0);
      end
   endtask

   task automatic test_zero_div();
      bit to;
      apply_reset();
      set_op(2, 5, 0, 1'b1, 1'b0);
      drain(100, to);
      tests_run++; if (to || rsp_idx_q.size() != 1 || rsp_data_q[0] !== 32'hFFFF_FFFF) begin
         tests_failed++; $display("FAIL zero_quot got %0d rsps (data %h) want ffffffff", rsp_idx_q.size(), (rsp_data_q.size() > 0) ? rsp_data_q[0] : 0);
      end
`ifdef DIV_ARB_ZERO_BYPASS_EN
      tests_run++; if (kick_cnt != 0) begin tests_failed++; $display("FAIL zero_kicks got %0d want 0", kick_cnt); end
      tests_run++; if (rsp_cyc - acc_cyc != 1) begin tests_failed++; $display("FAIL zero_latency got %0d want 1", rsp_cyc - acc_cyc); end
`else
      tests_run++; if (kick_cnt != 1) begin tests_failed++; $display("FAIL zero_kicks got %0d want 1", kick_cnt); end
`endif
      clear_obs();
      set_op(2, 5, 0, 1'b1, 1'b1);
      drain(100, to);
      tests_run++; if (to || rsp_idx_q.size() != 1 || rsp_data_q[0] !== 32'd5) begin
         tests_failed++; $display("FAIL zero_rem got %0d rsps (data %h) want 5", rsp_idx_q.size(), (rsp_data_q.size() > 0) ? rsp_data_q[0] : 0);
      end
   endtask

   task automatic test_random();
      bit to;
      int ptr;
      int w;
      logic [W-1:0] a, b;
      apply_reset();
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(0, 3) == 0) begin
               a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
               case ($urandom_range(0, 7))
                  0:       b = '0;
                  1:       b = '1;
                  2, 3:    b = $urandom;
                  default: b = $urandom_range(1, 1000);
               endcase
               set_op(i, a, b, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            end
         end
         cycle();
      end
      drain(500, to);
      tests_run++; if (to) begin tests_failed++; $display("FAIL rand_drain got timeout want idle"); end
      tests_run++; if (grant_q.size() < 10) begin tests_failed++; $display("FAIL rand_activity got %0d grants want >= 10", grant_q.size()); end
      tests_run++; if (rsp_idx_q.size() != grant_q.size() || rsp_data_q.size() != grant_q.size()) begin
         tests_failed++; $display("FAIL rand_rsp_count got %0d want %0d", rsp_idx_q.size(), grant_q.size());
      end
      ptr = 0;
      for (int g = 0; g < grant_q.size(); g++) begin
         w = -1;
         for (int j = 0; j < N; j++) if (w < 0 && mask_q[g][(ptr + j) % N]) w = (ptr + j) % N;
         tests_run++; if (grant_q[g] != w) begin tests_failed++; $display("FAIL rand_rr_%0d got %0d want %0d", g, grant_q[g], w); end
         ptr = (w + 1) % N;
      end
      for (int g = 0; g < rsp_idx_q.size() && g < grant_q.size() && g < rsp_data_q.size(); g++) begin
         tests_run++; if (rsp_idx_q[g] != grant_q[g] || rsp_data_q[g] !== exp_q[g]) begin
            tests_failed++; $display("FAIL rand_rsp_%0d got %0d:%h want %0d:%h", g, rsp_idx_q[g], rsp_data_q[g], grant_q[g], exp_q[g]);
         end
      end
      tests_run++; if (onehot_err != 0) begin tests_failed++; $display("FAIL rand_onehot got %0d want 0", onehot_err); end
   endtask

   initial begin
      pend = '0;
      hold_all = 1'b0;
      acc_last = '0;
      for (int i = 0; i < N; i++) begin
         op_a[i] = '0; op_b[i] = '0; op_u[i] = 1'b0; op_r[i] = 1'b0;
      end
      drive();
      clear_obs();
      test_reset();
      test_basic();
      test_signed();
      test_two_same_cycle();
      test_round_robin_all();
      test_reset_in_wait();
      test_zero_div();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got no finish want finish within 50000 cycles");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/div_arbiter.md
Name: div_arbiter

Overview:
- Shares one iterative `div` unit between NUM_REQ requesters, e.g. several executer instances or harts.
- Each requester presents an operand pair plus op selection. A round-robin arbiter grants one request at a time and sequences the divider kick/ready handshake.
- Returns quotient or remainder to the granted requester with a one-cycle response pulse.
- Sits between the execute stages and a single `div` instance.

Parameters:
NUM_REQ, 4, number of requester ports (2..8)
WIDTH, 32, operand/result width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
req_valid  in  NUM_REQ  request pending per requester; held until req_ready
req_ready  out  NUM_REQ  one-hot one-cycle accept pulse
req_unsigned  in  NUM_REQ  per requester: 1 = unsigned divide
req_rem  in  NUM_REQ  per requester: 0 = return quotient, 1 = return remainder
req_a  in  NUM_REQ*WIDTH  dividends; requester i at bits [i*WIDTH +: WIDTH]
req_b  in  NUM_REQ*WIDTH  divisors; same packing as req_a
rsp_valid  out  NUM_REQ  one-hot one-cycle result pulse
rsp_data  out  WIDTH  result; valid only while rsp_valid != 0
busy  out  1  high in every state except IDLE
div_kick  out  1  start pulse to divider
div_unsigned_flag  out  1  to divider
div_dividend  out  WIDTH  to divider
div_divider  out  WIDTH  to divider
div_ready  in  1  divider idle/result valid
div_quotient  in  WIDTH  from divider
div_remainder  in  WIDTH  from divider

Behaviour:
- Reset values: state IDLE, rr_ptr = 0, req_ready = 0, rsp_valid = 0, rsp_data = 0, div_kick = 0, div_* operands = 0, busy = 0.
- States: IDLE, KICK, WAIT, RESP.
- IDLE, any req_valid set:
  - Winner = first set bit searching upward from rr_ptr, wrapping at NUM_REQ.
  - Combinational req_ready[winner] = 1 this cycle.
  - Registered: latch operands, unsigned flag, rem flag and grant index.
  - rr_ptr <= (winner+1) mod NUM_REQ.
  - Go to KICK.
- IDLE, no request: req_ready = 0, no change.
- KICK: div_kick = 1 for exactly this cycle, operands stable on div_*. Go to WAIT with guard bit set.
- WAIT:
  - div_kick = 0; div_* operands held.
  - First WAIT cycle (guard set): div_ready ignored, guard cleared. This covers the divider's ready still high from the previous idle.
  - Later cycles: on div_ready = 1, capture div_quotient or div_remainder per rem flag into rsp_data, go to RESP.
- RESP:
  - rsp_valid[grant] = 1 for one cycle, rsp_data valid. Go to IDLE.
  - A new grant can occur on the following cycle.
- Latency: accept -> rsp_valid = 3 + divider compute cycles. Minimum accept-to-accept spacing is 4 + divider cycles.
- Requests not granted stay pending; their req_valid and operands must remain stable. The arbiter never drops a request.
- A requester may re-request in the cycle after its rsp_valid.
- Multiple simultaneous req_valid: exactly one req_ready bit per accept, never more.
- Reset in any state:
  - Returns to IDLE next cycle with all outputs at reset values.
  - An in-flight operation is discarded with no rsp_valid. The divider shares the same reset.
- rr_ptr wraps NUM_REQ-1 -> 0.
- Signed arithmetic is entirely the divider's; the arbiter only routes the flag.

Optional Feature:
DIV_ARB_ZERO_BYPASS_EN
- Defined: when the latched divisor == 0, KICK/WAIT are skipped and no div_kick is issued. The cycle after accept enters RESP directly with RISC-V results: quotient = all ones, remainder = dividend. Accept-to-response latency is 1 cycle.
- Undefined: divide-by-zero goes to the divider like any other operation; the result is whatever the divider produces.

Test Plan:
- Requester 1: a=100, b=7, unsigned, rem=0 -> req_ready=0010 on the same cycle, one div_kick, rsp_valid=0010 with rsp_data=14. Repeat with rem=1 -> 2.
- Requester 0: a=-7 (0xFFFFFFF9), b=2, signed -> quotient 0xFFFFFFFD (-3); rem=1 -> 0xFFFFFFFF (-1).
- Requesters 0 and 2 raised on the same cycle, held -> grants in order 0 then 2; rsp_valid 0001 then 0100; never two req_ready bits at once.
- All four req_valid held continuously with rr_ptr=0 -> grant sequence 0,1,2,3,0,1; exactly one kick per grant.
- Reset asserted during WAIT -> next cycle busy=0, div_kick=0, no rsp_valid ever issued for that op; a fresh 9/3 request then returns 3.
- With DIV_ARB_ZERO_BYPASS_EN: a=5, b=0 -> div_kick never asserted; rsp_data=0xFFFFFFFF (rem=0) or 5 (rem=1) one cycle after accept. Without the macro, div_kick is asserted.
